// File: rtl/rv_defs.sv
// Shared RV32I constants and the fetch-queue entry type
// used by the predecode buffer and its queue.
package rv_defs;

  localparam int RV_ILEN = 32;

  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_JALR  = 5'b11001;

  localparam logic [2:0] FUNC_ADD = 3'b000;

  typedef struct packed {
    logic [RV_ILEN-1:0] ir;
    logic [RV_ILEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/rv_predecode_fifo.sv
// Circular instruction queue: storage, pointers and occupancy,
// exposing the head entry and the instruction behind it.
module rv_predecode_fifo
  import rv_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  fq_entry_t                din_i,
  output fq_entry_t                head_o,
  output logic [RV_ILEN-1:0]       next_ir_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_q, wr_q, rd_nx;
  logic [CW-1:0] count_q;
  fq_entry_t     mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (kill_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      if (push_i && !pop_i) count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  // Power-of-two depth lets the pointer wrap by overflow.
  assign rd_nx     = rd_q + AW'(1);
  assign head_o    = mem_q[rd_q];
  assign next_ir_o = mem_q[rd_nx].ir;
  assign count_o   = count_q;

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) count_q <= FULL);
  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(pop_i && !kill_i && count_q == '0));
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && !kill_i && !pop_i && count_q == FULL));

endmodule

// File: rtl/rv_predecode_buf.sv
// Fetch-to-execute buffer presenting the head instruction predecoded,
// with one-cycle-lookahead regfile read addresses.
module rv_predecode_buf
  import rv_defs::*;
#(
  parameter int DEPTH     = 2,
  parameter int ALU_REUSE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_valid_i,
  output logic        f_ready_o,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  input  logic        x_kill_i,
  output logic        x_valid_o,
  input  logic        x_ready_i,
  output logic [31:0] x_pc_o,
  output logic [31:0] x_ir_o,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic [4:0]  x_rs1_o,
  output logic [4:0]  x_rs2_o,
  output logic [4:0]  x_rd_o,
  output logic [4:0]  x_opcode_o,
  output logic [4:0]  x_shamt_o,
  output logic [2:0]  x_fun_o,
  output logic        x_shifter_sign_o,
  output logic        x_illegal_o,
  output logic [31:0] x_imm_i_o,
  output logic [31:0] x_imm_s_o,
  output logic [31:0] x_imm_b_o,
  output logic [31:0] x_imm_u_o,
  output logic [31:0] x_imm_j_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_entry_t           din, head;
  logic [RV_ILEN-1:0]  next_ir, ir;
  logic [CW-1:0]       count;
  logic                push, pop;

  assign f_ready_o = (count != FULL);
  assign x_valid_o = (count != '0);
  assign push = f_valid_i & f_ready_o & ~x_kill_i;
  assign pop  = x_valid_o & x_ready_i & ~x_kill_i;
  assign din  = '{ir: f_ir_i, pc: f_pc_i};

  rv_predecode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .pop_i     (pop),
    .kill_i    (x_kill_i),
    .din_i     (din),
    .head_o    (head),
    .next_ir_o (next_ir),
    .count_o   (count)
  );

  assign ir     = head.ir;
  assign x_ir_o = ir;
  assign x_pc_o = head.pc;

  assign x_rs1_o          = ir[19:15];
  assign x_rs2_o          = ir[24:20];
  assign x_rd_o           = ir[11:7];
  assign x_opcode_o       = ir[6:2];
  assign x_shamt_o        = ir[24:20];
  assign x_shifter_sign_o = ir[30];
  assign x_illegal_o      = (ir[1:0] != 2'b11);

  assign x_imm_i_o = {{21{ir[31]}}, ir[30:20]};
  assign x_imm_s_o = {{21{ir[31]}}, ir[30:25], ir[11:7]};
  assign x_imm_b_o = {{20{ir[31]}}, ir[7], ir[30:25],
                      ir[11:8], 1'b0};
  assign x_imm_u_o = {ir[31:12], 12'h0};
  assign x_imm_j_o = {{12{ir[31]}}, ir[19:12], ir[20],
                      ir[30:21], 1'b0};

  // Jumps and upper-immediates reuse the adder for target/result.
  always_comb begin
    x_fun_o = ir[14:12];
    if (ALU_REUSE != 0) begin
      unique case (ir[6:2])
        OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: x_fun_o = FUNC_ADD;
        default: ;
      endcase
    end
  end

  always_comb begin
    rf_rs1_o = ir[19:15];
    rf_rs2_o = ir[24:20];
    if (x_kill_i || count == '0 || (pop && count == CW'(1))) begin
      rf_rs1_o = f_ir_i[19:15];
      rf_rs2_o = f_ir_i[24:20];
    end else if (pop) begin
      rf_rs1_o = next_ir[19:15];
      rf_rs2_o = next_ir[24:20];
    end
  end

endmodule
